// File: rtl/pattern_ctrl_pkg.sv
// Shared definitions for the pattern detection controller.
//   state_t    : controller FSM states (IDLE, SHIFT, DONE)
//   DATA_W_DEF : default frame width in bits
//   PAT_W_DEF  : default pattern width in bits
//   COUNT_W    : width of the match counter
//   COUNT_SAT  : value at which the match counter saturates
package pattern_ctrl_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int PAT_W_DEF  = 4;
    localparam int COUNT_W    = 4;

    localparam logic [COUNT_W-1:0] COUNT_SAT = 4'd15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_match_engine.sv
// Serial pattern match engine: shifts in one bit per enabled cycle, compares
// the most recent PAT_W bits against the pattern and counts matches
// (overlapping matches count, saturating at COUNT_SAT).
// Ports:
//   clk     in  1        clock
//   clr     in  1        clears history, fill tracking and count
//   bit_en  in  1        a new bit is presented on bit_in
//   bit_in  in  1        serial data bit
//   pattern in  PAT_W    pattern to compare against
//   count   out COUNT_W  number of matches since the last clr
module seq_match_engine
    import pattern_ctrl_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               bit_en,
    input  logic               bit_in,
    input  logic [PAT_W-1:0]   pattern,
    output logic [COUNT_W-1:0] count
);

    logic [PAT_W-1:0]   r_hist;
    logic [PAT_W-1:0]   r_fill;
    logic               r_match_p1;
    logic [COUNT_W-1:0] r_count;

    logic [PAT_W-1:0]   w_hist_next;
    logic [PAT_W-1:0]   w_fill_next;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
        return (c == COUNT_SAT) ? c : c + 1'b1;
    endfunction

    assign w_hist_next = {r_hist[PAT_W-2:0], bit_in};
    // r_fill is a thermometer of bits seen; its MSB marks a full window so
    // bits from an earlier frame can never form a match.
    assign w_fill_next = {r_fill[PAT_W-2:0], 1'b1};

    // Stage p0 -> p1: shift in the bit and register the compare result
    // Stage p1 -> count: fold a registered match into the saturating counter
    always_ff @(posedge clk) begin
        if (clr) begin
            r_hist     <= '0;
            r_fill     <= '0;
            r_match_p1 <= 1'b0;
            r_count    <= '0;
        end else begin
            if (bit_en) begin
                r_hist <= w_hist_next;
                r_fill <= w_fill_next;
            end
            r_match_p1 <= bit_en & w_fill_next[PAT_W-1] & (w_hist_next == pattern);
            if (r_match_p1) begin
                r_count <= sat_inc(r_count);
            end
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pattern_detect_ctrl.sv
// Two-requester pattern detection controller. A round-robin arbiter accepts
// one frame at a time, streams it MSB first through seq_match_engine and
// holds the result until the consumer takes it.
// Ports:
//   clk         in  1        clock
//   reset       in  1        synchronous active-high reset
//   req_valid   in  2        per-requester frame valid
//   req_data0   in  DATA_W   requester 0 frame
//   req_data1   in  DATA_W   requester 1 frame
//   req_ready   out 2        one-hot grant (only in IDLE)
//   cfg_pattern in  PAT_W    pattern, captured at accept
//   rsp_valid   out 1        result valid (DONE state)
//   rsp_ready   in  1        consumer accepts result
//   rsp_id      out 1        requester of this result
//   rsp_count   out 4        overlapping match count
//   rsp_hit     out 1        rsp_count != 0
//   busy        out 1        state != IDLE
module pattern_detect_ctrl
    import pattern_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int PAT_W  = PAT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [DATA_W-1:0] req_data1,
    output logic [1:0]        req_ready,
    input  logic [PAT_W-1:0]  cfg_pattern,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [3:0]        rsp_count,
    output logic              rsp_hit,
    output logic              busy
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_last_grant;
    logic               r_id;
    logic               r_drain;
    logic [DATA_W-1:0]  r_frame;
    logic [PAT_W-1:0]   r_pattern;
    logic [IDX_W-1:0]   r_bit_idx;

    logic [1:0]         w_grant;
    logic               w_accept;
    logic               w_accept_id;
    logic               w_bit_en;
    logic               w_eng_clr;
    logic [COUNT_W-1:0] w_count;

    // Round-robin: on a tie the requester not granted last wins.
    always_comb begin
        w_grant = 2'b00;
        if (r_state == IDLE && !reset) begin
            case (req_valid)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11:   w_grant = r_last_grant ? 2'b01 : 2'b10;
                default: w_grant = 2'b00;
            endcase
        end
    end

    assign w_accept    = |(req_valid & w_grant);
    assign w_accept_id = w_grant[1];
    // SHIFT holds one extra drain cycle so the registered compare of the
    // last bit reaches the counter before DONE.
    assign w_bit_en    = (r_state == SHIFT) && !r_drain;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_state_next = SHIFT;
            SHIFT:   if (r_drain)   w_state_next = DONE;
            DONE:    if (rsp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_drain      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_last_grant <= w_accept_id;
                r_id         <= w_accept_id;
                r_drain      <= 1'b0;
            end else if (w_bit_en && r_bit_idx == '0) begin
                r_drain <= 1'b1;
            end
        end
    end

    // Frame, pattern and bit index are only meaningful after an accept.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_frame   <= w_accept_id ? req_data1 : req_data0;
            r_pattern <= cfg_pattern;
            r_bit_idx <= IDX_W'(DATA_W - 1);
        end else if (w_bit_en && r_bit_idx != '0) begin
            r_bit_idx <= r_bit_idx - 1'b1;
        end
    end

    assign w_eng_clr = reset | w_accept;

    seq_match_engine #(
        .PAT_W (PAT_W)
    ) u_engine (
        .clk     (clk),
        .clr     (w_eng_clr),
        .bit_en  (w_bit_en),
        .bit_in  (r_frame[r_bit_idx]),
        .pattern (r_pattern),
        .count   (w_count)
    );

    assign req_ready = w_grant;
    assign rsp_valid = (r_state == DONE);
    assign rsp_id    = r_id;
    assign rsp_count = w_count;
    assign rsp_hit   = (w_count != '0);
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_pattern_detect_ctrl.sv
module tb_pattern_detect_ctrl;

    localparam int DATA_W = 8;
    localparam int PAT_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        req_valid;
    logic [DATA_W-1:0] req_data0;
    logic [DATA_W-1:0] req_data1;
    logic [1:0]        req_ready;
    logic [PAT_W-1:0]  cfg_pattern;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [3:0]        rsp_count;
    logic              rsp_hit;
    logic              busy;

    pattern_detect_ctrl #(.DATA_W(DATA_W), .PAT_W(PAT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data0   (req_data0),
        .req_data1   (req_data1),
        .req_ready   (req_ready),
        .cfg_pattern (cfg_pattern),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_count   (rsp_count),
        .rsp_hit     (rsp_hit),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       id;
        logic [3:0] cnt;
        int         edge_n;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   m_last   = 1'b1;
    bit   stall    = 1'b0;
    bit   seen     = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: slide a PAT_W window over the frame and count equal windows.
    function automatic logic [3:0] ref_count(input logic [DATA_W-1:0] f, input logic [PAT_W-1:0] p);
        int c = 0;
        logic [DATA_W-1:0] w;
        for (int i = 0; i <= DATA_W - PAT_W; i++) begin
            w = f >> i;
            if (w[PAT_W-1:0] == p) c++;
        end
        if (c > 15) c = 15;
        return 4'(c);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Consumer readiness: random, or held low while stalling.
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            rsp_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor / scoreboard.
    always begin
        @(negedge clk);
        #1;
        if (reset) begin
            seen = 1'b0;
        end else if (rsp_valid) begin
            if (q.size() == 0) begin
                check("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                check("rsp_id", 32'(rsp_id), 32'(q[0].id));
                check("rsp_count", 32'(rsp_count), 32'(q[0].cnt));
                check("rsp_hit", 32'(rsp_hit), 32'(q[0].cnt != 0));
                check("ready_in_done", 32'(req_ready), 32'd0);
                if (!seen) check("latency", 32'(cyc - q[0].edge_n), 32'(DATA_W + 1));
                seen = 1'b1;
                if (rsp_ready) begin
                    void'(q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic issue(input logic [1:0] vm, input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                         input logic [PAT_W-1:0] pat, input logic [PAT_W-1:0] after, input bit push);
        logic w;
        int   n;
        exp_t e;
        w = (vm == 2'b11) ? ~m_last : vm[1];
        @(negedge clk);
        req_valid   = vm;
        req_data0   = d0;
        req_data1   = d1;
        cfg_pattern = pat;
        #1;
        n = 0;
        while (req_ready == 2'b00 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("grant", 32'(req_ready), w ? 32'd2 : 32'd1);
        if (req_ready == 2'b00) begin
            req_valid = 2'b00;
            return;
        end
        e.id     = w;
        e.cnt    = ref_count(w ? d1 : d0, pat);
        e.edge_n = cyc + 1;
        if (push) q.push_back(e);
        m_last = w;
        @(negedge clk);
        req_valid   = 2'b00;
        cfg_pattern = after;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain", 32'(q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_id"},    32'(rsp_id),    32'd0);
        check({tag, "_rsp_count"}, 32'(rsp_count), 32'd0);
        check({tag, "_rsp_hit"},   32'(rsp_hit),   32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]        vm;
        logic [DATA_W-1:0] d0, d1;
        logic [PAT_W-1:0]  p;
        int                n;

        reset       = 1'b1;
        req_valid   = 2'b00;
        req_data0   = '0;
        req_data1   = '0;
        cfg_pattern = '0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("por");
        reset = 1'b0;

        // Both requesters contending: alternate starting with req0.
        for (int i = 0; i < 4; i++) issue(2'b11, 8'hA5, 8'h5A, 4'b1010, 4'b1010, 1'b1);

        issue(2'b01, 8'b0101_0101, 8'h00, 4'b0101, 4'b0101, 1'b1);
        issue(2'b01, 8'hFF, 8'h00, 4'b1111, 4'b0000, 1'b1);
        issue(2'b10, 8'h33, 8'h00, 4'b0101, 4'b1111, 1'b1);
        // Pattern changes mid-frame must not affect the frame in flight.
        issue(2'b01, 8'b0101_0101, 8'h00, 4'b0101, 4'b1111, 1'b1);

        // Consumer stall for 20 cycles with both requesters waiting.
        issue(2'b01, 8'hC3, 8'h00, 4'b0011, 4'b1001, 1'b1);
        stall = 1'b1;
        n = 0;
        while (!rsp_valid && n < 30) begin
            @(negedge clk);
            #1;
            n++;
        end
        req_valid = 2'b11;
        repeat (20) begin
            @(negedge clk);
            #1;
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 2'b00;
        stall     = 1'b0;
        n = 0;
        while (rsp_valid && n < 30) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("stall_idle", 32'(busy), 32'd0);
        check("stall_q", 32'(q.size()), 32'd0);

        // Reset on the 4th SHIFT cycle discards the frame.
        wait_drain();
        issue(2'b11, 8'hFF, 8'hFF, 4'b1111, 4'b1111, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        m_last = 1'b1;
        #1;
        check_reset_outputs("midrst");
        issue(2'b11, 8'h0F, 8'hF0, 4'b1111, 4'b0000, 1'b1);

        // Randomized traffic, with occasional requests dropped while busy.
        for (int t = 0; t < 40; t++) begin
            vm = 2'($urandom_range(1, 3));
            d0 = DATA_W'($urandom);
            d1 = DATA_W'($urandom);
            p  = ($urandom_range(0, 1) == 1) ? d0[PAT_W-1:0] : PAT_W'($urandom);
            issue(vm, d0, d1, p, PAT_W'($urandom), 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                req_valid = 2'($urandom_range(1, 3));
                req_data0 = DATA_W'($urandom);
                #1;
                check("drop_ready", 32'(req_ready), 32'd0);
                @(negedge clk);
                req_valid = 2'b00;
            end
        end

        wait_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
